// File: rtl/uart_frame_loader.sv
// uart_frame_loader: parses UART byte commands (0xA5 frame, 0x5A fill, 0x3C prescale)
// and drives the LED matrix pixel stream with backpressure and an inter-byte timeout.
module uart_frame_loader #(
  parameter int PANEL_ROWS     = 64,
  parameter int PANEL_COLS     = 64,
  parameter int COLOR_DEPTH    = 4,
  parameter int TIMEOUT_CYCLES = 500000,
  parameter int PRESCALE_INIT  = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx_valid,
  output logic                     rx_ready,
  input  logic [7:0]               rx_data,
  output logic                     pix_valid,
  input  logic                     pix_ready,
  output logic                     pix_sync,
  output logic [3*COLOR_DEPTH-1:0] pix_rgb,
  output logic [7:0]               prescale,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     err_timeout
);

  localparam int PIXELS = PANEL_ROWS * PANEL_COLS;
  localparam int CNT_W  = (PIXELS > 1) ? $clog2(PIXELS) : 1;
  localparam int TMO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int RGB_W  = 3 * COLOR_DEPTH;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PIX_HI   = 3'd1,
    ST_PIX_LO   = 3'd2,
    ST_PIX_OUT  = 3'd3,
    ST_FILL_HI  = 3'd4,
    ST_FILL_LO  = 3'd5,
    ST_FILL_OUT = 3'd6,
    ST_CFG      = 3'd7
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         hi_q, hi_d;
  logic [RGB_W-1:0]   rgb_q, rgb_d;
  logic               pix_valid_q, pix_valid_d;
  logic               pix_sync_q, pix_sync_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [7:0]         prescale_q, prescale_d;
  logic               frame_done_q, frame_done_d;
  logic               err_timeout_q, err_timeout_d;
  logic               rx_ready_q, rx_ready_d;
  logic               busy_q, busy_d;

  logic               byte_acc_s;
  logic               beat_acc_s;
  logic               wait_st_s;
  logic               tmo_hit_s;
  logic               last_pix_s;

  assign byte_acc_s = rx_valid && rx_ready_q;
  assign beat_acc_s = pix_valid_q && pix_ready;
  assign last_pix_s = (cnt_q == CNT_W'(PIXELS - 1));
  assign wait_st_s  = (state_q == ST_PIX_HI)  || (state_q == ST_PIX_LO) ||
                      (state_q == ST_FILL_HI) || (state_q == ST_FILL_LO) ||
                      (state_q == ST_CFG);
  assign tmo_hit_s  = wait_st_s && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  // Command FSM next-state and registered-output next values.
  always_comb begin
    state_d       = state_q;
    hi_d          = hi_q;
    rgb_d         = rgb_q;
    pix_valid_d   = pix_valid_q;
    pix_sync_d    = pix_sync_q;
    cnt_d         = cnt_q;
    prescale_d    = prescale_q;
    frame_done_d  = 1'b0;
    err_timeout_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (byte_acc_s) begin
          case (rx_data)
            8'hA5: begin
              state_d = ST_PIX_HI;
              cnt_d   = '0;
            end
            8'h5A:   state_d = ST_FILL_HI;
            8'h3C:   state_d = ST_CFG;
            default: state_d = ST_IDLE;
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PIX_HI, ST_FILL_HI: begin
        if (byte_acc_s) begin
          hi_d    = rx_data;
          state_d = (state_q == ST_PIX_HI) ? ST_PIX_LO : ST_FILL_LO;
        end else begin
          state_d = state_q;
        end
      end
      ST_PIX_LO: begin
        if (byte_acc_s) begin
          rgb_d       = RGB_W'({hi_q, rx_data});
          pix_valid_d = 1'b1;
          pix_sync_d  = (cnt_q == '0);
          state_d     = ST_PIX_OUT;
        end else begin
          state_d = ST_PIX_LO;
        end
      end
      ST_PIX_OUT: begin
        if (beat_acc_s) begin
          pix_valid_d = 1'b0;
          pix_sync_d  = 1'b0;
          if (last_pix_s) begin
            frame_done_d = 1'b1;
            cnt_d        = '0;
            state_d      = ST_IDLE;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = ST_PIX_HI;
          end
        end else begin
          state_d = ST_PIX_OUT;
        end
      end
      ST_FILL_LO: begin
        if (byte_acc_s) begin
          rgb_d       = RGB_W'({hi_q, rx_data});
          pix_valid_d = 1'b1;
          pix_sync_d  = 1'b1;
          cnt_d       = '0;
          state_d     = ST_FILL_OUT;
        end else begin
          state_d = ST_FILL_LO;
        end
      end
      ST_FILL_OUT: begin
        // valid stays high between beats so a ready-high downstream sees no bubbles
        if (beat_acc_s) begin
          pix_sync_d = 1'b0;
          if (last_pix_s) begin
            pix_valid_d  = 1'b0;
            frame_done_d = 1'b1;
            cnt_d        = '0;
            state_d      = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          state_d = ST_FILL_OUT;
        end
      end
      ST_CFG: begin
        if (byte_acc_s) begin
          prescale_d = rx_data;
          state_d    = ST_IDLE;
        end else begin
          state_d = ST_CFG;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        pix_valid_d = 1'b0;
        pix_sync_d  = 1'b0;
      end
    endcase

    // an accepted byte on the expiry cycle takes priority over the abort
    if (tmo_hit_s && !byte_acc_s) begin
      state_d       = ST_IDLE;
      err_timeout_d = 1'b1;
    end else begin
      err_timeout_d = err_timeout_d;
    end

    rx_ready_d = (state_d != ST_PIX_OUT) && (state_d != ST_FILL_OUT);
    busy_d     = (state_d != ST_IDLE);
  end

  // Inter-byte timeout counter: clears on bytes and state changes, frozen outside wait states.
  always_comb begin
    tmo_d = tmo_q;
    if (byte_acc_s || (state_d != state_q)) begin
      tmo_d = '0;
    end else if (wait_st_s) begin
      tmo_d = tmo_q + TMO_W'(1);
    end else begin
      tmo_d = tmo_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      hi_q          <= 8'h00;
      rgb_q         <= '0;
      pix_valid_q   <= 1'b0;
      pix_sync_q    <= 1'b0;
      cnt_q         <= '0;
      tmo_q         <= '0;
      prescale_q    <= 8'(PRESCALE_INIT);
      frame_done_q  <= 1'b0;
      err_timeout_q <= 1'b0;
      rx_ready_q    <= 1'b1;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      hi_q          <= hi_d;
      rgb_q         <= rgb_d;
      pix_valid_q   <= pix_valid_d;
      pix_sync_q    <= pix_sync_d;
      cnt_q         <= cnt_d;
      tmo_q         <= tmo_d;
      prescale_q    <= prescale_d;
      frame_done_q  <= frame_done_d;
      err_timeout_q <= err_timeout_d;
      rx_ready_q    <= rx_ready_d;
      busy_q        <= busy_d;
    end
  end

  assign rx_ready    = rx_ready_q;
  assign pix_valid   = pix_valid_q;
  assign pix_sync    = pix_sync_q;
  assign pix_rgb     = rgb_q;
  assign prescale    = prescale_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_uart_frame_loader.sv
// Directed bench for uart_frame_loader: command table plus frame, fill, timeout,
// stall and reset sequences checked against hand-computed expectations.
module tb_uart_frame_loader;

  localparam int PIXELS = 4096;
  localparam int TMO    = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  rx_data = 8'h00;
  logic        pix_valid;
  logic        pix_ready = 1'b0;
  logic        pix_sync;
  logic [11:0] pix_rgb;
  logic [7:0]  prescale;
  logic        busy;
  logic        frame_done;
  logic        err_timeout;

  uart_frame_loader #(
    .PANEL_ROWS(64), .PANEL_COLS(64), .COLOR_DEPTH(4),
    .TIMEOUT_CYCLES(TMO), .PRESCALE_INIT(3)
  ) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_sync(pix_sync), .pix_rgb(pix_rgb),
    .prescale(prescale), .busy(busy), .frame_done(frame_done), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // monitor controls (written by the stimulus process only)
  logic        mon_clr   = 1'b1;
  logic        fill_mode = 1'b0;
  logic [11:0] exp_const = 12'h000;
  logic [11:0] exp_base  = 12'h000;

  // monitor results (written by the monitor only)
  int          beats, sync_cnt, sync_bad, rgb_bad, stall_bad, bubble_bad;
  int          done_cnt, err_cnt, both_bad;
  logic        prev_stall;
  logic [11:0] prev_rgb;
  logic        prev_sync;

  // Stream monitor sampling on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (mon_clr) begin
      beats <= 0; sync_cnt <= 0; sync_bad <= 0; rgb_bad <= 0; stall_bad <= 0;
      bubble_bad <= 0; done_cnt <= 0; err_cnt <= 0; both_bad <= 0;
      prev_stall <= 1'b0; prev_rgb <= 12'h000; prev_sync <= 1'b0;
    end else begin
      if (pix_valid && prev_stall && ((pix_rgb != prev_rgb) || (pix_sync != prev_sync)))
        stall_bad <= stall_bad + 1;
      if (fill_mode && (beats > 0) && (beats < PIXELS) && !pix_valid)
        bubble_bad <= bubble_bad + 1;
      if (pix_valid && pix_ready) begin
        if (pix_rgb != (fill_mode ? exp_const : (beats[11:0] + exp_base)))
          rgb_bad <= rgb_bad + 1;
        if (pix_sync != (beats == 0)) sync_bad <= sync_bad + 1;
        if (pix_sync) sync_cnt <= sync_cnt + 1;
        beats <= beats + 1;
      end
      prev_stall <= pix_valid && !pix_ready;
      prev_rgb   <= pix_rgb;
      prev_sync  <= pix_sync;
      if (frame_done) done_cnt <= done_cnt + 1;
      if (err_timeout) err_cnt <= err_cnt + 1;
      if (frame_done && err_timeout) both_bad <= both_bad + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    tick();
    mon_clr = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int w;
    w = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && (w < 64)) begin
      tick();
      w++;
    end
    if (!rx_ready) check("rx_ready_wait", {31'd0, rx_ready}, 32'd1);
    else tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_pixel(input logic [11:0] n);
    send_byte({4'h0, n[11:8]});
    send_byte(n[7:0]);
  endtask

  task automatic wait_done();
    for (int i = 0; (i < 40) && (done_cnt == 0); i++) tick();
    tick();
    tick();
  endtask

  typedef struct {
    logic [7:0] b;
    logic       busy;
    logic       rdy;
    logic [7:0] pre;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int k;
    int loc_bad;

    // byte sent in IDLE/CFG, then busy / rx_ready / prescale one cycle later
    vecs[0]  = '{8'h11, 1'b0, 1'b1, 8'h03};
    vecs[1]  = '{8'h3C, 1'b1, 1'b1, 8'h03};
    vecs[2]  = '{8'h07, 1'b0, 1'b1, 8'h07};
    vecs[3]  = '{8'h00, 1'b0, 1'b1, 8'h07};
    vecs[4]  = '{8'h3C, 1'b1, 1'b1, 8'h07};
    vecs[5]  = '{8'hFF, 1'b0, 1'b1, 8'hFF};
    vecs[6]  = '{8'hC3, 1'b0, 1'b1, 8'hFF};
    vecs[7]  = '{8'h3C, 1'b1, 1'b1, 8'hFF};
    vecs[8]  = '{8'hA5, 1'b0, 1'b1, 8'hA5};
    vecs[9]  = '{8'h3C, 1'b1, 1'b1, 8'hA5};
    vecs[10] = '{8'h07, 1'b0, 1'b1, 8'h07};

    // reset with inputs active
    rst = 1'b1; rx_valid = 1'b1; rx_data = 8'hA5; pix_ready = 1'b1;
    tick(); tick(); tick();
    check("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
    check("rst_pix_valid", {31'd0, pix_valid}, 32'd0);
    check("rst_pix_sync", {31'd0, pix_sync}, 32'd0);
    check("rst_pix_rgb", {20'd0, pix_rgb}, 32'd0);
    check("rst_prescale", {24'd0, prescale}, 32'd3);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_pulses", {30'd0, frame_done, err_timeout}, 32'd0);
    rx_valid = 1'b0;
    rst = 1'b0;
    clear_mon();

    for (int i = 0; i < 11; i++) begin
      send_byte(vecs[i].b);
      tick();
      check($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].busy});
      check($sformatf("vec%0d_rx_ready", i), {31'd0, rx_ready}, {31'd0, vecs[i].rdy});
      check($sformatf("vec%0d_prescale", i), {24'd0, prescale}, {24'd0, vecs[i].pre});
    end

    // byte arriving on the very cycle the timeout would fire wins
    send_byte(8'h3C);
    for (int i = 0; i < TMO - 1; i++) tick();
    send_byte(8'h2A);
    check("race_err", {31'd0, err_timeout}, 32'd0);
    check("race_prescale", {24'd0, prescale}, 32'h2A);
    check("race_err_cnt", err_cnt, 32'd0);

    // CFG timeout: pulse TMO cycles after entry, prescale untouched
    send_byte(8'h3C);
    k = 0;
    for (int i = 1; (i <= 150) && (k == 0); i++) begin
      tick();
      if (err_timeout) k = i;
    end
    check("cfg_tmo_cycle", k, TMO);
    check("cfg_tmo_prescale", {24'd0, prescale}, 32'h2A);
    check("cfg_tmo_busy", {31'd0, busy}, 32'd0);
    tick();
    check("cfg_tmo_pulse_width", {31'd0, err_timeout}, 32'd0);

    // full frame, pixel n carries n
    pix_ready = 1'b1; fill_mode = 1'b0; exp_base = 12'h000;
    clear_mon();
    send_byte(8'hA5);
    for (int n = 0; n < PIXELS; n++) send_pixel(n[11:0]);
    wait_done();
    check("frame_beats", beats, PIXELS);
    check("frame_rgb_bad", rgb_bad, 32'd0);
    check("frame_sync_cnt", sync_cnt, 32'd1);
    check("frame_sync_bad", sync_bad, 32'd0);
    check("frame_done_cnt", done_cnt, 32'd1);
    check("frame_err_cnt", err_cnt, 32'd0);
    check("frame_busy", {31'd0, busy}, 32'd0);

    // solid fill with ready toggling every cycle
    pix_ready = 1'b0; fill_mode = 1'b1; exp_const = 12'hF00;
    clear_mon();
    send_byte(8'h5A); send_byte(8'h0F); send_byte(8'h00);
    for (int i = 0; (i < 10000) && (done_cnt == 0); i++) begin
      pix_ready = ~pix_ready;
      tick();
    end
    pix_ready = 1'b1;
    tick(); tick();
    check("fill_beats", beats, PIXELS);
    check("fill_rgb_bad", rgb_bad, 32'd0);
    check("fill_sync_cnt", sync_cnt, 32'd1);
    check("fill_sync_bad", sync_bad, 32'd0);
    check("fill_stall_bad", stall_bad, 32'd0);
    check("fill_bubble_bad", bubble_bad, 32'd0);
    check("fill_done_cnt", done_cnt, 32'd1);
    check("fill_busy", {31'd0, busy}, 32'd0);

    // partial frame then silence: one beat in PIX_OUT, then TMO cycles in PIX_HI
    fill_mode = 1'b0; exp_base = 12'h000;
    clear_mon();
    send_byte(8'hA5);
    for (int n = 0; n < 10; n++) send_pixel(n[11:0]);
    k = 0;
    for (int i = 1; (i <= 200) && (k == 0); i++) begin
      tick();
      if (err_timeout) k = i;
    end
    check("pix_tmo_cycle", k, TMO + 1);
    tick();
    check("pix_tmo_beats", beats, 32'd10);
    check("pix_tmo_err_cnt", err_cnt, 32'd1);
    check("pix_tmo_done_cnt", done_cnt, 32'd0);
    check("pix_tmo_busy", {31'd0, busy}, 32'd0);

    // next frame restarts at pixel 0 with sync
    exp_base = 12'hABC;
    clear_mon();
    send_byte(8'hA5);
    send_pixel(12'hABC);
    for (int i = 0; (i < 200) && (err_cnt == 0); i++) tick();
    check("restart_beats", beats, 32'd1);
    check("restart_sync_cnt", sync_cnt, 32'd1);
    check("restart_rgb_bad", rgb_bad, 32'd0);
    check("restart_both_bad", both_bad, 32'd0);

    // long downstream stall mid-frame: no timeout, rx_ready low throughout
    exp_base = 12'h000;
    clear_mon();
    loc_bad = 0;
    send_byte(8'hA5);
    for (int n = 0; n < PIXELS; n++) begin
      if (n == 2000) begin
        logic [11:0] p;
        p = n[11:0];
        send_byte({4'h0, p[11:8]});
        pix_ready = 1'b0;
        send_byte(p[7:0]);
        for (int i = 0; i < 5 * TMO; i++) begin
          tick();
          if (rx_ready || err_timeout || !pix_valid) loc_bad++;
        end
        pix_ready = 1'b1;
      end else begin
        send_pixel(n[11:0]);
      end
    end
    wait_done();
    check("stall_hold_bad", loc_bad, 32'd0);
    check("stall_beats", beats, PIXELS);
    check("stall_rgb_bad", rgb_bad, 32'd0);
    check("stall_stable_bad", stall_bad, 32'd0);
    check("stall_err_cnt", err_cnt, 32'd0);
    check("stall_done_cnt", done_cnt, 32'd1);

    // reset while a fill beat is pending
    pix_ready = 1'b0;
    send_byte(8'h5A); send_byte(8'h12); send_byte(8'h34);
    tick();
    check("mid_fill_valid", {31'd0, pix_valid}, 32'd1);
    rst = 1'b1;
    tick();
    check("mid_rst_valid", {31'd0, pix_valid}, 32'd0);
    check("mid_rst_prescale", {24'd0, prescale}, 32'd3);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_rx_ready", {31'd0, rx_ready}, 32'd1);
    check("mid_rst_rgb", {19'd0, pix_sync, pix_rgb}, 32'd0);
    rst = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation still running at time limit, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_frame_loader.md
Name: uart_frame_loader

Overview:
Command controller between the UART receive stream and the LED matrix pixel input. It parses byte commands to stream a full frame, fill the panel with one colour, or set the matrix prescale value. It drives the frame-sync, valid and rgb pixel stream with backpressure. Malformed or stalled transfers are aborted by an inter-byte timeout.

Parameters:
PANEL_ROWS, 64, matrix rows
PANEL_COLS, 64, matrix columns
COLOR_DEPTH, 4, bits per colour channel; legal range 1..5
TIMEOUT_CYCLES, 500000, idle clk cycles allowed between bytes inside a command
PRESCALE_INIT, 3, reset value of prescale

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
rx_valid  in  1  UART byte available
rx_ready  out  1  byte accepted when rx_valid && rx_ready
rx_data  in  8  UART byte
pix_valid  out  1  pixel beat valid
pix_ready  in  1  downstream accepts beat
pix_sync  out  1  high on the beat carrying pixel 0 of a frame
pix_rgb  out  3*COLOR_DEPTH  pixel colour, {R,G,B}
prescale  out  8  matrix prescale configuration
busy  out  1  high in any state except IDLE
frame_done  out  1  one-cycle pulse after the last pixel handshake
err_timeout  out  1  one-cycle pulse on timeout abort

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: state=IDLE; rx_ready=1; pix_valid=0; pix_sync=0; pix_rgb=0; prescale=PRESCALE_INIT; busy=0; frame_done=0; err_timeout=0; pixel counter=0; timeout counter=0.
- PIXELS = PANEL_ROWS*PANEL_COLS. The pixel counter is $clog2(PIXELS) bits wide.
- A pixel is 2 bytes, high byte first. The 16-bit word supplies pix_rgb from bits [3*COLOR_DEPTH-1:0]; higher bits are ignored.
- Accepted byte: rx_valid && rx_ready. Accepted beat: pix_valid && pix_ready.
- rx_ready is 1 in IDLE, PIX_HI, PIX_LO, FILL_HI, FILL_LO and CFG. It is 0 in PIX_OUT and FILL_OUT.
- IDLE:
  - 0xA5 -> PIX_HI, counter=0.
  - 0x5A -> FILL_HI.
  - 0x3C -> CFG.
  - Any other byte is consumed and dropped; state stays IDLE.
- PIX_HI: on byte, latch the high byte -> PIX_LO.
- PIX_LO: on byte, next cycle pix_valid=1 with pix_rgb from {hi,lo} and pix_sync=(counter==0) -> PIX_OUT.
- PIX_OUT:
  - pix_valid, pix_rgb and pix_sync are held stable until the beat is accepted.
  - On the accepted beat, pix_valid and pix_sync drop next cycle.
  - If counter==PIXELS-1: frame_done pulses next cycle -> IDLE.
  - Otherwise: counter++ -> PIX_HI.
- FILL_HI / FILL_LO: latch the 2-byte colour, then counter=0 -> FILL_OUT.
- FILL_OUT:
  - pix_valid is held 1 for PIXELS consecutive accepted beats; no bubbles are permitted while pix_ready=1.
  - pix_sync=1 only while counter==0.
  - After the last accepted beat, frame_done pulses -> IDLE.
- CFG: on byte, prescale<=rx_data next cycle -> IDLE. prescale changes only here or on reset.
- Timeout:
  - Counter runs in PIX_HI, PIX_LO, FILL_HI, FILL_LO and CFG. It clears on each accepted byte and on state entry.
  - On reaching TIMEOUT_CYCLES-1: err_timeout pulses, state -> IDLE. Partial frames are abandoned with no frame_done, and prescale is unchanged.
  - The counter is frozen in the OUT states; downstream stalls never time out.
- Simultaneous byte and timeout on the same cycle: the byte wins and the timeout counter clears.
- Reset mid-operation:
  - Returns to IDLE the next cycle with all outputs at reset values, and prescale returns to PRESCALE_INIT.
  - A pending pix_valid is dropped without handshake.
- frame_done and err_timeout are never high together.

Test Plan:
- Reset with rx_valid=1, pix_ready=1 -> rx_ready=1, pix_valid=0, prescale=3, busy=0. After release, IDLE behaviour starts.
- Send 0xA5 then 4096 pixels where pixel n=n[11:0], pix_ready=1 -> 4096 beats with rgb=n[11:0]; pix_sync only on beat 0; one frame_done pulse; busy drops to 0.
- Send 0x5A,0x0F,0x00 with pix_ready toggling 1/0 each cycle -> exactly 4096 beats of rgb=0xF00; rgb stable during stalls; pix_sync on first beat only; frame_done once.
- Send 0x3C,0x07 -> prescale=7 two cycles after the last byte. Send 0x11 in IDLE -> dropped, no state change, busy=0.
- Send 0xA5 plus 10 pixels, then silence for TIMEOUT_CYCLES (set to 100) -> err_timeout pulse at cycle 100, IDLE, no frame_done. A following 0xA5 frame has pix_sync on its first pixel.
- Hold pix_ready=0 for 10 ms mid-frame -> no err_timeout, rx_ready=0 throughout; the frame completes after ready returns. Assert rst mid-FILL_OUT -> pix_valid=0 next cycle and prescale=3.
